// File: rtl/adder_4.sv
// ============================================================================
// Module   : adder_4
// Purpose  : Registered 4-bit ripple-carry adder with carry-in/carry-out.
//            Optional ovf/zero flags are built when ADDER_4_FLAGS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       out_valid
`ifdef ADDER_4_FLAGS_EN
  ,
  output logic       ovf,
  output logic       zero
`endif
);

  localparam int c_width = 4;

  logic [c_width:0]   w_carry;
  logic [c_width-1:0] w_sum;

  logic [c_width-1:0] r_sum;
  logic               r_c_out;
  logic               r_out_valid;

  assign w_carry[0] = c_in;

  // Explicit full-adder chain, bit 0 through bit 3.
  for (genvar i = 0; i < c_width; i++) begin : g_stage
    logic w_p;
    assign w_p          = a[i] ^ b[i];
    assign w_sum[i]     = w_p ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & w_p);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= 4'h0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_c_out <= w_carry[c_width];
      end
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign out_valid = r_out_valid;

`ifdef ADDER_4_FLAGS_EN
  logic w_ovf;
  logic w_zero;
  logic r_ovf;
  logic r_zero;

  // Overflow when the carry into the sign bit differs from the carry out of it.
  assign w_ovf  = w_carry[c_width-1] ^ w_carry[c_width];
  assign w_zero = (w_sum == 4'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else if (in_valid) begin
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign ovf  = r_ovf;
  assign zero = r_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_4.sv
// ============================================================================
// Module   : tb_adder_4
// Purpose  : Self-checking bench for adder_4 against an arithmetic reference.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       c_in = 1'b0;
  logic [3:0] sum;
  logic       c_out;
  logic       out_valid;
`ifdef ADDER_4_FLAGS_EN
  logic       ovf;
  logic       zero;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_sum;
  logic       exp_c_out;
  logic       exp_out_valid;
  logic       exp_ovf;
  logic       exp_zero;

  adder_4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
`ifdef ADDER_4_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_outputs(input string tag);
    checks++;
    assert (sum === exp_sum) else begin
      errors++;
      $error("FAIL %s sum observed %h expected %h", tag, sum, exp_sum);
    end
    checks++;
    assert (c_out === exp_c_out) else begin
      errors++;
      $error("FAIL %s c_out observed %b expected %b", tag, c_out, exp_c_out);
    end
    checks++;
    assert (out_valid === exp_out_valid) else begin
      errors++;
      $error("FAIL %s out_valid observed %b expected %b", tag, out_valid, exp_out_valid);
    end
`ifdef ADDER_4_FLAGS_EN
    checks++;
    assert (ovf === exp_ovf) else begin
      errors++;
      $error("FAIL %s ovf observed %b expected %b", tag, ovf, exp_ovf);
    end
    checks++;
    assert (zero === exp_zero) else begin
      errors++;
      $error("FAIL %s zero observed %b expected %b", tag, zero, exp_zero);
    end
`endif
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge,
  // then compare shortly after it.
  task automatic step(input logic rn, input logic v, input logic [3:0] aa,
                      input logic [3:0] bb, input logic ci, input string tag);
    int total;
    int sa;
    int sb;
    int ssum;
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    a        = aa;
    b        = bb;
    c_in     = ci;
    @(posedge clk);
    if (!rn) begin
      exp_sum       = 4'h0;
      exp_c_out     = 1'b0;
      exp_out_valid = 1'b0;
      exp_ovf       = 1'b0;
      exp_zero      = 1'b1;
    end else begin
      exp_out_valid = v;
      if (v) begin
        total     = int'(aa) + int'(bb) + int'(ci);
        exp_sum   = 4'(total % 16);
        exp_c_out = (total >= 16);
        sa        = (aa > 7) ? int'(aa) - 16 : int'(aa);
        sb        = (bb > 7) ? int'(bb) - 16 : int'(bb);
        ssum      = sa + sb + int'(ci);
        exp_ovf   = (ssum > 7) || (ssum < -8);
        exp_zero  = (total % 16) == 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, "reset0");
    step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, "reset1");

    step(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, "carry_wrap");
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, "maximum");
    step(1'b1, 1'b1, 4'h7, 4'h1, 1'b0, "ovf_pos");
    step(1'b1, 1'b1, 4'h8, 4'h8, 1'b0, "ovf_neg");
    step(1'b1, 1'b1, 4'h3, 4'h4, 1'b1, "hold_load");
    step(1'b1, 1'b0, 4'h1, 4'h1, 1'b0, "hold0");
    step(1'b1, 1'b0, 4'hA, 4'h5, 1'b1, "hold1");

    // Exhaustive back-to-back sweep with one reset edge in the middle.
    for (int i = 0; i < 512; i++) begin
      if (i == 300)
        step(1'b0, 1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8), "sweep_reset");
      else
        step(1'b1, 1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8), "sweep");
    end

    // Random burst with sporadic valid drops.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
           1'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
